mac_arbiter: RTL

MAC_ARBITER -- requirements
Module: mac_arbiter

---
 rtl/mac_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mac_arbiter.sv
// Two-requester round-robin dot-product MAC: one job per grant, res_vld one cycle after the last pair.
// Backpressure: rdy is high only for the granted requester while RUN; dropping req mid-job aborts silently.
module mac_arbiter #(
  parameter int          MAX_LEN       = 4,
  parameter logic [15:0] INITIAL_VALUE = 16'h0000
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic [1:0]  req,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  input  logic [1:0]  vld,
  input  logic [1:0]  last,
  output logic [1:0]  gnt,
  output logic [1:0]  rdy,
  output logic [15:0] res,
  output logic        res_vld,
  output logic        res_id,
  output logic        res_ovf,
  output logic        res_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_LEN);

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        gid_q, gid_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic        last_id_q, last_id_d;
  logic [15:0] res_q, res_d;
  logic        res_vld_q, res_vld_d;
  logic        res_id_q, res_id_d;
  logic        res_ovf_q, res_ovf_d;
  logic        res_err_q, res_err_d;
  logic        busy_q, busy_d;

  logic [7:0]  a_sel, b_sel;
  logic        vld_sel, last_sel, req_sel;
  logic [15:0] prod;
  logic [16:0] sum;

  assign a_sel    = gid_q ? a1 : a0;
  assign b_sel    = gid_q ? b1 : b0;
  assign vld_sel  = gid_q ? vld[1] : vld[0];
  assign last_sel = gid_q ? last[1] : last[0];
  assign req_sel  = gid_q ? req[1] : req[0];
  assign prod     = 16'(a_sel) * 16'(b_sel);
  assign sum      = {1'b0, acc_q} + {1'b0, prod};

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gid_d     = gid_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    last_id_d = last_id_q;
    res_d     = res_q;
    res_vld_d = 1'b0;
    res_id_d  = res_id_q;
    res_ovf_d = res_ovf_q;
    res_err_d = res_err_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = RUN;
          // On a tie the requester that did not finish the previous job wins.
          gid_d   = (req == 2'b11) ? ~last_id_q : req[1];
          gnt_d   = gid_d ? 2'b10 : 2'b01;
          acc_d   = INITIAL_VALUE;
          cnt_d   = 4'd0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (!req_sel) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end else if (vld_sel) begin
          cnt_d = cnt_q + 4'd1;
          if (sum[16]) begin
            ovf_d = 1'b1;
          end else if (!ovf_q) begin
            acc_d = sum[15:0];
          end
          if (!last_sel && cnt_d == MAX_CNT) begin
            err_d = 1'b1;
          end
          if (last_sel || cnt_d == MAX_CNT) begin
            state_d   = DONE;
            res_vld_d = 1'b1;
            res_d     = acc_d;
            res_id_d  = gid_q;
            res_ovf_d = ovf_d;
            res_err_d = err_d;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        gnt_d     = 2'b00;
        last_id_d = gid_q;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      gid_q     <= 1'b0;
      acc_q     <= INITIAL_VALUE;
      cnt_q     <= 4'd0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      last_id_q <= 1'b1;
      res_q     <= INITIAL_VALUE;
      res_vld_q <= 1'b0;
      res_id_q  <= 1'b0;
      res_ovf_q <= 1'b0;
      res_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gid_q     <= gid_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      last_id_q <= last_id_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      res_id_q  <= res_id_d;
      res_ovf_q <= res_ovf_d;
      res_err_q <= res_err_d;
      busy_q    <= busy_d;
    end
  end

  // rdy is gated by btnC so no pair is acknowledged in a cycle that reset will discard.
  assign rdy     = (state_q == RUN && !btnC) ? gnt_q : 2'b00;
  assign gnt     = gnt_q;
  assign res     = res_q;
  assign res_vld = res_vld_q;
  assign res_id  = res_id_q;
  assign res_ovf = res_ovf_q;
  assign res_err = res_err_q;
  assign busy    = busy_q;

endmodule
